burst_check_engine: RTL and testbench
=====================================

Name: burst_check_engine

Overview:
- Transaction engine that drives the `valid`/`done`/`data_ok` handshake consumed by the downstream hold/clean checker stage.
- Accepts a start request with a beat count and seed, then checks an incoming beat stream against an incrementing expected pattern.
- Holds `valid` high for the whole transfer, pulses `done` exactly once, and reports data integrity on `data_ok`.
- A timeout guarantees `done` always arrives.

Parameters:
- DATA_W, 8, beat data width.
- LEN_W, 8, width of the beat-count field; max burst is 2^LEN_W-1 beats.
- TIMEOUT, 16, consecutive beat-less cycles in RUN before a forced finish; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- len  input  LEN_W  number of beats; captured with start.
- seed  input  DATA_W  expected value of the first beat; captured with start.
- beat_valid  input  1  beat present this cycle.
- beat_data  input  DATA_W  beat payload.
- valid  output  1  transfer in progress; high from the cycle after start through the done cycle inclusive.
- done  output  1  one-cycle completion pulse; always coincides with valid=1.
- data_ok  output  1  high while every beat of the current transfer has matched; meaningful only when valid=1.
- err_mismatch  output  1  sticky; set by any mismatching beat; cleared on the next accepted start.
- err_timeout  output  1  sticky; set by a timeout finish; cleared on the next accepted start.
- beat_cnt  output  LEN_W  beats accepted in the current or last transfer.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs, beat_cnt, expected and the idle timer are 0, immediately and regardless of clk.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 and len!=0 → RUN next cycle.
    - Captures len and expected=seed.
    - Clears beat_cnt and both error flags.
    - Sets valid=1 and data_ok=1.
  - start with len=0 is ignored (no valid).
  - beat_valid is ignored.
- RUN, each cycle with beat_valid=1:
  - beat_data compared to expected.
  - expected <= expected+1, wrapping modulo 2^DATA_W.
  - beat_cnt increments.
  - Idle timer cleared.
  - On mismatch: data_ok <= 0 and err_mismatch <= 1 (visible next cycle). data_ok never re-rises within the transfer.
  - When the accepted beat makes beat_cnt == len: → DONE.
- RUN, cycle with beat_valid=0:
  - Idle timer increments.
  - On reaching TIMEOUT: → DONE with err_timeout <= 1 and data_ok <= 0.
- DONE (exactly one cycle):
  - valid=1, done=1.
  - data_ok reflects all beats, including the final beat.
  - beat_valid and start are ignored.
  - Next cycle: IDLE with valid=0, done=0, data_ok=0.
- Latency:
  - start sampled at cycle t → valid=1 at t+1.
  - Final beat sampled at k → done=1 at k+1.
  - valid=0 at k+2.
- Minimum gap between transfers: one IDLE cycle, so valid drops for at least one cycle.
- start while not IDLE is ignored.
- len = 2^LEN_W-1 must complete without beat_cnt overflow.
- Simultaneous final beat and timeout threshold: the beat wins; this is a normal finish with no err_timeout.
- Reset mid-transfer aborts immediately; no done pulse is produced.
- Invariants, for the checker:
  - valid rises only from IDLE.
  - valid stays high continuously until done.
  - done never occurs with valid=0.
  - A clean transfer keeps data_ok=1 from the valid rise through the done cycle.

Decomposition:
- Package burst_check_pkg:
  - state_e enum {IDLE, RUN, DONE}.
  - Default DATA_W, LEN_W and TIMEOUT localparams.
- One sub-module, burst_idle_timer:
  - Parameter TIMEOUT.
  - Inputs: clk, rst_n, clear, tick.
  - Output: expired.
  - Saturating counter of width $clog2(TIMEOUT+1).

Test Plan:
- Clean burst: seed=8'h10, len=4; beats 10,11,12,13 on consecutive cycles → valid high 5 cycles; done on the 5th; data_ok=1 throughout; beat_cnt=4; no error flags.
- Mismatch: seed=8'h20, len=3; beats 20,25,22 → data_ok falls the cycle after beat 25 and stays 0 through done; err_mismatch=1; done still arrives after 3 beats.
- Timeout: len=5, TIMEOUT=16; send 2 beats, then silence → done 16 cycles after the last beat; err_timeout=1; data_ok=0 on the done cycle; beat_cnt=2.
- Wrap and gaps: seed=8'hFE, len=4; beats FE,FF,00,01 with 3-cycle gaps → clean completion; no timeout.
- Boundaries: start with len=0 → no valid. start during RUN → ignored. Back-to-back start on the cycle after done → accepted; the valid rise appears one cycle after IDLE.
- Reset mid-burst: rst_n low asynchronously at beat 2 of 4 → valid, done and data_ok drop without waiting for clk; no done pulse; a fresh transfer after release completes normally.

Source files
------------

// File: rtl/burst_check_pkg.sv
// Shared types and default sizing for the burst check engine.
package burst_check_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned LEN_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/burst_idle_timer.sv
// Saturating count of consecutive beat-less RUN cycles; flags the cycle that reaches TIMEOUT.
module burst_idle_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the threshold in the same cycle so the FSM finishes after exactly TIMEOUT idle cycles.
  assign expired = tick && !clear && (cnt_d == CW'(TIMEOUT));

endmodule

// File: rtl/burst_check_engine.sv
// Burst transfer engine: checks a beat stream against an incrementing pattern and
// drives the valid/done/data_ok handshake with a timeout-guaranteed finish.
module burst_check_engine
  import burst_check_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] seed,
  input  logic              beat_valid,
  input  logic [DATA_W-1:0] beat_data,
  output logic              valid,
  output logic              done,
  output logic              data_ok,
  output logic              err_mismatch,
  output logic              err_timeout,
  output logic [LEN_W-1:0]  beat_cnt
);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              data_ok_q, data_ok_d;
  logic              err_mm_q, err_mm_d;
  logic              err_to_q, err_to_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] exp_q, exp_d;

  logic timer_clear;
  logic timer_tick;
  logic timer_expired;

  assign timer_clear = (state_q != RUN) || beat_valid;
  assign timer_tick  = (state_q == RUN) && !beat_valid;

  burst_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (timer_expired)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    data_ok_d  = data_ok_q;
    err_mm_d   = err_mm_q;
    err_to_d   = err_to_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    exp_d      = exp_q;

    unique case (state_q)
      IDLE: begin
        valid_d   = 1'b0;
        data_ok_d = 1'b0;
        if (start && (len != '0)) begin
          state_d    = RUN;
          valid_d    = 1'b1;
          data_ok_d  = 1'b1;
          err_mm_d   = 1'b0;
          err_to_d   = 1'b0;
          beat_cnt_d = '0;
          len_d      = len;
          exp_d      = seed;
        end
      end

      RUN: begin
        if (beat_valid) begin
          exp_d      = exp_q + DATA_W'(1);
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (beat_data != exp_q) begin
            data_ok_d = 1'b0;
            err_mm_d  = 1'b1;
          end
          if ((beat_cnt_q + LEN_W'(1)) == len_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (timer_expired) begin
          state_d   = DONE;
          done_d    = 1'b1;
          data_ok_d = 1'b0;
          err_to_d  = 1'b1;
        end
      end

      DONE: begin
        state_d   = IDLE;
        valid_d   = 1'b0;
        data_ok_d = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        valid_d   = 1'b0;
        data_ok_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      data_ok_q  <= 1'b0;
      err_mm_q   <= 1'b0;
      err_to_q   <= 1'b0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      data_ok_q  <= data_ok_d;
      err_mm_q   <= err_mm_d;
      err_to_q   <= err_to_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      exp_q      <= exp_d;
    end
  end

  assign valid        = valid_q;
  assign done         = done_q;
  assign data_ok      = data_ok_q;
  assign err_mismatch = err_mm_q;
  assign err_timeout  = err_to_q;
  assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_burst_check_engine.sv
// Scoreboard bench for burst_check_engine: directed transfers push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_burst_check_engine;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] seed;
  logic              beat_valid;
  logic [DATA_W-1:0] beat_data;
  logic              valid;
  logic              done;
  logic              data_ok;
  logic              err_mismatch;
  logic              err_timeout;
  logic [LEN_W-1:0]  beat_cnt;

  burst_check_engine #(
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .seed         (seed),
    .beat_valid   (beat_valid),
    .beat_data    (beat_data),
    .valid        (valid),
    .done         (done),
    .data_ok      (data_ok),
    .err_mismatch (err_mismatch),
    .err_timeout  (err_timeout),
    .beat_cnt     (beat_cnt)
  );

  always #5 clk = ~clk;

  // Directed vector: stimulus plus hand-computed results.
  typedef struct {
    int seed;
    int len;
    int nbeats;
    int gap;       // idle cycles before each beat
    int bad_idx;   // beat index carrying bad_val, -1 for none
    int bad_val;
    int start_mid; // raise start with beat 1 (must be ignored)
    int e_ok;
    int e_mm;
    int e_to;
    int e_cnt;
    int e_vcyc;    // cycles with valid=1, done cycle included
    int e_gap;     // beat-less valid cycles immediately before done
    int e_fall;    // 1-based valid cycle where data_ok first reads 0, 0 = never
  } vec_t;

  typedef struct {
    int ok;
    int mm;
    int to;
    int cnt;
    int vcyc;
    int gap;
    int fall;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: tracks the transfer shape and checks it against the scoreboard on done.
  int   m_vcyc = 0;
  int   m_gap  = 0;
  int   m_fall = 0;
  exp_t m_e;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vcyc = 0;
      m_gap  = 0;
      m_fall = 0;
    end else if (!clk) begin
      if (done) chk("done_with_valid", int'(valid), 1);
      if (valid) begin
        m_vcyc++;
        if (!data_ok && m_fall == 0) m_fall = m_vcyc;
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            m_e = sb_q.pop_front();
            chk("data_ok", int'(data_ok), m_e.ok);
            chk("err_mismatch", int'(err_mismatch), m_e.mm);
            chk("err_timeout", int'(err_timeout), m_e.to);
            chk("beat_cnt", int'(beat_cnt), m_e.cnt);
            chk("valid_cycles", m_vcyc, m_e.vcyc);
            chk("idle_before_done", m_gap, m_e.gap);
            chk("data_ok_fall", m_fall, m_e.fall);
          end
          m_vcyc = 0;
          m_gap  = 0;
          m_fall = 0;
        end else begin
          m_gap = beat_valid ? 0 : m_gap + 1;
        end
      end
    end
  end

  // Issues start in the current (IDLE) cycle and returns in the first IDLE cycle after done.
  task automatic run_xfer(input vec_t v);
    exp_t e;
    int   n;
    e.ok = v.e_ok; e.mm = v.e_mm; e.to = v.e_to; e.cnt = v.e_cnt;
    e.vcyc = v.e_vcyc; e.gap = v.e_gap; e.fall = v.e_fall;
    sb_q.push_back(e);
    start = 1'b1;
    len   = LEN_W'(v.len);
    seed  = DATA_W'(v.seed);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < v.nbeats; i++) begin
      for (int g = 0; g < v.gap; g++) begin
        @(posedge clk); #1;
      end
      beat_valid = 1'b1;
      beat_data  = (i == v.bad_idx) ? DATA_W'(v.bad_val) : DATA_W'(v.seed + i);
      if (v.start_mid != 0 && i == 1) begin
        start = 1'b1;
        len   = LEN_W'(1);
      end
      @(posedge clk); #1;
      beat_valid = 1'b0;
      start      = 1'b0;
    end
    n = 0;
    while (valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_drops", int'(valid), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_data_ok", int'(data_ok), 0);
  endtask

  vec_t vecs[6];

  initial begin
    //                seed   len  nb  gap bad bval mid ok mm to cnt vcyc gap fall
    vecs[0] = '{32'h10,    4,   4,  0, -1,    0, 0, 1, 0, 0,   4,   5,  0,  0};
    vecs[1] = '{32'h20,    3,   3,  0,  1, 'h25, 1, 0, 1, 0,   3,   4,  0,  3};
    vecs[2] = '{32'h30,    5,   2,  0, -1,    0, 0, 0, 0, 1,   2,  19, 16, 19};
    vecs[3] = '{32'hFE,    4,   4,  3, -1,    0, 0, 1, 0, 0,   4,  17,  0,  0};
    vecs[4] = '{32'h80,  255, 255,  0, -1,    0, 0, 1, 0, 0, 255, 256,  0,  0};
    vecs[5] = '{32'h40,    4,   4,  0, -1,    0, 0, 1, 0, 0,   4,   5,  0,  0};

    rst_n = 1'b0; start = 1'b0; len = '0; seed = '0;
    beat_valid = 1'b0; beat_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_data_ok", int'(data_ok), 0);
    chk("rst_err_mm", int'(err_mismatch), 0);
    chk("rst_err_to", int'(err_timeout), 0);
    chk("rst_beat_cnt", int'(beat_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back transfers: each start lands in the IDLE cycle right after done.
    for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

    // Zero-length start is ignored.
    start = 1'b1; len = '0; seed = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_no_valid", int'(valid), 0);
    @(posedge clk); #1;
    chk("len0_still_idle", int'(valid), 0);

    // Asynchronous reset during beat 2 of 4.
    start = 1'b1; len = 8'd4; seed = 8'h40;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_valid", int'(valid), 1);
    beat_valid = 1'b1; beat_data = 8'h40;
    @(posedge clk); #1;
    beat_data = 8'h41;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_data_ok", int'(data_ok), 0);
    chk("async_rst_beat_cnt", int'(beat_cnt), 0);
    beat_valid = 1'b0;
    @(posedge clk); #1;
    chk("in_rst_no_done", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_xfer(vecs[5]);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
